// File: rtl/quad_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_gen
// Purpose  : Quadrature A/B generator. Walks an internal position toward a
//            loaded target, one Gray-code edge per step, with a fixed number
//            of clocks between edges. Takes the shortest modular path; a tie
//            goes forward.
// Revision : 1.0 - initial release
// ============================================================================
module quad_gen #(
  parameter int WIDTH    = 10,
  parameter int STEP_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active-low
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  input  logic             hold,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  // Timer only has to hold STEP_DIV-1, so clog2(STEP_DIV) bits are enough.
  localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0]    RELOAD = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0]    T_ONE  = TW'(1);
  localparam logic [WIDTH-1:0] P_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] HALF   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] target_reg;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] diff;
  logic             forward;
  logic [WIDTH-1:0] next_pos;

  // Direction and next position: shortest modular path, exact half goes forward.
  always_comb begin
    diff     = target_reg - position;
    forward  = (diff <= HALF);
    next_pos = forward ? (position + P_ONE) : (position - P_ONE);
  end

  assign busy = (position != target_reg);

  // Target capture, step timer, position and A/B encoding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_reg <= '0;
      position   <= '0;
      timer      <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        target_reg <= target;
      end
      if (!busy) begin
        // Idle keeps the timer at zero so a fresh load steps on the next edge.
        timer <= '0;
      end else if (!hold) begin
        if (timer == '0) begin
          position <= next_pos;
          // Gray code of position[1:0]: 0->00, 1->10, 2->11, 3->01.
          a        <= next_pos[1] ^ next_pos[0];
          b        <= next_pos[1];
          timer    <= RELOAD;
          done     <= (next_pos == target_reg);
        end else begin
          timer <= timer - T_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/quad_gen.md
Name: quad_gen

Overview:
- Quadrature signal generator: the transmit end of the paddle A/B interface.
- Drives a/b from an internal position toward a loaded target, one Gray-code edge per step, at a fixed edge rate slow enough to pass the paddle debouncer.
- Used as an on-chip paddle emulator (attract/demo mode, CPU opponent) and as bench stimulus for the paddle decode path.
- Its position output mirrors the count the paddle decoder must report.

Parameters:
- WIDTH, 10, width of target and position; matches the paddle move width.
- STEP_DIV, 1000, clocks between successive a/b edges; legal range 2 to 2^20.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- load  input  1  one-cycle strobe; captures target.
- target  input  WIDTH  requested position; sampled only when load=1.
- hold  input  1  1 = freeze stepping (timer and position held).
- a  output  1  quadrature channel A, registered.
- b  output  1  quadrature channel B, registered.
- position  output  WIDTH  current emitted position, registered.
- busy  output  1  1 while position != target register.
- done  output  1  one-cycle pulse on the edge where position becomes equal to target.

Behaviour:
- Reset (reset=0, async): a=0, b=0, position=0, target reg=0, step timer=0, done=0; busy=0.
- Encoding: {a,b} forward sequence 00 -> 10 -> 11 -> 01 -> 00 (A leads B). Reverse walks the sequence backward.
- Count rule: position +1 per forward edge, -1 per reverse edge. Counting is x4: 4 counts per full cycle.
- Invariant: {a,b} always equals the Gray code of position[1:0] (00,10,11,01 for 0..3).
- Exactly one of a/b changes per edge; both never change on the same clock.
- Load: on a rising edge with load=1, target reg <= target. Accepted whether idle, busy or held.
- Load while busy: re-targets immediately. The timer is not restarted, and direction is re-evaluated at the next step.
- Direction: diff = (target reg - position) mod 2^WIDTH.
  - diff=0: idle.
  - 1 <= diff <= 2^(WIDTH-1): forward.
  - Otherwise: reverse.
  - Shortest path wins; a tie (diff = 512 at WIDTH=10) goes forward.
- Wrap-around: position is modular. Forward from 1023 gives 0; reverse from 0 gives 1023. a/b continue the sequence seamlessly across the wrap.
- Step timer:
  - Idle: held at 0.
  - Busy, hold=0: when timer=0, emit one edge and reload the timer to STEP_DIV-1. Otherwise decrement.
- Latency: load sampled at edge N from idle -> first a/b change and position update at edge N+1. Each subsequent edge follows STEP_DIV clocks after the previous one.
- hold=1: timer, position, a and b frozen; busy still reflects the state. Releasing hold resumes with the timer value at freeze.
- done: asserted on the same edge that makes position equal the target reg; low the next cycle unless another arrival occurs.
- Load of a value equal to position when idle: no edges, done=0, busy stays 0.
- Load of a value equal to position while busy: stepping stops immediately. done=0, because no arrival edge occurs.
- busy is combinational from the registers: (position != target reg).
- Reset mid-motion: outputs return to reset values at once. The pending target is discarded.

Test Plan:
- Reset/idle, STEP_DIV=4: release reset, wait 20 clk -> a=b=0, position=0, busy=0, done never pulses.
- Forward move: load target=6 -> edges at N+1, +5, +9, ...; {a,b} = 10,11,01,00,10,11; position 1..6; done pulse on the 6th edge; busy falls on that same edge.
- Reverse with wrap: from position 0, load 1021 -> 3 reverse edges, {a,b} = 01,11,10, position 1023,1022,1021; no step ever changes both a and b.
- Tie and shortest path: from 0, load 512 -> forward, 512 edges, ends with {a,b}=00. From 0, load 513 -> reverse, 511 edges.
- Re-target and hold, from 0:
  - Load 10; after 3 edges (position 3), load 1 -> reverses to 1 with unchanged edge spacing.
  - Assert hold for 50 clk mid-move -> no a/b activity; the move resumes after release.
- Async reset mid-move: drop reset between clock edges during a move -> a, b, position and done clear without waiting for clk. After release, no motion until a new load.
